// File: rtl/shift_frame_sched_pkg.sv
// shift_frame_sched_pkg: shared state encoding and sizing helpers for shift_frame_sched.
package shift_frame_sched_pkg;
  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;
  function automatic int frame_bits(input int rows, input int cols);
    return rows * cols;
  endfunction
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/shift_frame_sched_rr_pick.sv
// rr_pick: combinational round-robin pick of the first set request at or after ptr.
module rr_pick
  import shift_frame_sched_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int W = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [W-1:0]    ptr,
  output logic [W-1:0]    grant,
  output logic            any
);
  logic [NREQ-1:0] rot;
  // Walk from the farthest candidate inwards so the nearest one to ptr wins.
  always_comb begin
    rot = NREQ'({req, req} >> ptr);
    grant = '0;
    for (int i = NREQ - 1; i >= 0; i--)
      if (rot[i]) grant = W'((int'(ptr) + i) % NREQ);
  end
  assign any = |req;
endmodule

// File: rtl/shift_frame_sched.sv
// shift_frame_sched: round-robin owner of a serial-in packed shift array, drained one row per handshake.
// Define SHIFT_FRAME_SCHED_TRACE_EN to print every accepted output row.
module shift_frame_sched
  import shift_frame_sched_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int ROWS = 3,
  parameter int COLS = 5,
  parameter int ROW_BASE = 0,
  parameter int COL_BASE = 0
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ-1:0]         req_bit,
  output logic [NREQ-1:0]         req_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [COLS-1:0]         out_data,
  output logic [idx_w(ROWS)-1:0]  out_row,
  output logic [idx_w(NREQ)-1:0]  out_src
);
  localparam int FB = frame_bits(ROWS, COLS);
  localparam int IW = idx_w(NREQ);
  localparam int RW = idx_w(ROWS);
  localparam int CW = $clog2(FB + 1);
  state_t state;
  logic [ROW_BASE+ROWS-1:ROW_BASE][COL_BASE+COLS-1:COL_BASE] arr;
  logic [FB-1:0] shifted;
  logic [CW-1:0] cnt;
  logic [IW-1:0] ptr;
  logic [IW-1:0] grant;
  logic any;
  rr_pick #(.NREQ(NREQ), .W(IW)) u_pick (
    .req(req_valid),
    .ptr(ptr),
    .grant(grant),
    .any(any)
  );
  // Element [ROW_BASE][COL_BASE] is the LSB, so one shift step is a left shift of the flat array.
  assign shifted = FB'({arr, req_bit[out_src]});
  function automatic logic [COLS-1:0] row_of(input logic [FB-1:0] v, input int r);
    return COLS'(v >> ((r - ROW_BASE) * COLS));
  endfunction
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
      arr <= '0;
      cnt <= '0;
      ptr <= '0;
      req_ready <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_row <= '0;
      out_src <= '0;
    end else begin
      case (state)
        IDLE: if (any) begin
          out_src <= grant;
          req_ready <= NREQ'(1) << grant;
          state <= FILL;
        end
        FILL: if (req_valid[out_src] && req_ready[out_src]) begin
          arr <= shifted;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(FB - 1)) begin
            req_ready <= '0;
            out_valid <= 1'b1;
            out_row <= RW'(ROWS - 1);
            out_data <= row_of(shifted, ROW_BASE + ROWS - 1);
            state <= DRAIN;
          end
        end
        DRAIN: if (out_ready) begin
`ifdef SHIFT_FRAME_SCHED_TRACE_EN
          $display($time, " shift_frame_sched src=", out_src, " row=", out_row, " data=", out_data);
`endif
          if (out_row == '0) begin
            out_valid <= 1'b0;
            cnt <= '0;
            ptr <= (out_src == IW'(NREQ - 1)) ? '0 : out_src + 1'b1;
            state <= IDLE;
          end else begin
            out_row <= out_row - 1'b1;
            out_data <= row_of(arr, ROW_BASE + int'(out_row) - 1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_shift_frame_sched.sv
// tb_shift_frame_sched: directed and randomized frames checked against a bit-queue model, on default and negative-base builds.
module tb_shift_frame_sched;
  localparam int NREQ = 2;
  localparam int ROWS = 3;
  localparam int COLS = 5;
  localparam int FB = ROWS * COLS;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic out_ready = 1'b1;
  logic [NREQ-1:0] req_valid = '0;
  logic [NREQ-1:0] req_bit = '0;
  logic [NREQ-1:0] rdy_a, rdy_b;
  logic ov_a, ov_b;
  logic [COLS-1:0] od_a, od_b;
  logic [1:0] row_a, row_b;
  logic src_a, src_b;
  int checks = 0;
  int errors = 0;
  int ptr_m = 0;

  always #5 clock = ~clock;

  shift_frame_sched dut_a (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_bit(req_bit),
    .req_ready(rdy_a), .out_valid(ov_a), .out_ready(out_ready), .out_data(od_a),
    .out_row(row_a), .out_src(src_a)
  );
  shift_frame_sched #(.ROW_BASE(-1), .COL_BASE(-3)) dut_b (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_bit(req_bit),
    .req_ready(rdy_b), .out_valid(ov_b), .out_ready(out_ready), .out_data(od_b),
    .out_row(row_b), .out_src(src_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic outs(input string tag, input logic ev, input logic [NREQ-1:0] erdy,
                      input int esrc, input bit full, input int erow, input logic [COLS-1:0] ed);
    chk({tag, ".valid_a"}, 32'(ov_a), 32'(ev));
    chk({tag, ".valid_b"}, 32'(ov_b), 32'(ev));
    chk({tag, ".ready_a"}, 32'(rdy_a), 32'(erdy));
    chk({tag, ".ready_b"}, 32'(rdy_b), 32'(erdy));
    if (esrc >= 0) begin
      chk({tag, ".src_a"}, 32'(src_a), esrc);
      chk({tag, ".src_b"}, 32'(src_b), esrc);
    end
    if (full) begin
      chk({tag, ".row_a"}, 32'(row_a), erow);
      chk({tag, ".row_b"}, 32'(row_b), erow);
      chk({tag, ".data_a"}, 32'(od_a), 32'(ed));
      chk({tag, ".data_b"}, 32'(od_b), 32'(ed));
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    req_valid = '0;
    out_ready = 1'b1;
    step();
    reset_n = 1'b1;
    ptr_m = 0;
    outs(tag, 1'b0, '0, 0, 1'b1, 0, '0);
  endtask

  // bits[k] is the k-th accepted bit of the frame; abort_at>=0 resets after that many accepted bits.
  task automatic frame(input string tag, input logic [NREQ-1:0] vmask, input logic [FB-1:0] bits,
                       input bit toggle, input int stall_row, input int stall_n, input int abort_at);
    int g;
    int k;
    int cyc;
    logic v;
    logic [COLS-1:0] exp_row;
    g = -1;
    for (int i = 0; i < NREQ; i++)
      if (g < 0 && vmask[(ptr_m + i) % NREQ]) g = (ptr_m + i) % NREQ;
    req_valid = vmask;
    req_bit = NREQ'($urandom);
    outs({tag, ".idle"}, 1'b0, '0, -1, 1'b0, 0, '0);
    step();
    k = 0;
    cyc = 0;
    while (k < FB && cyc < 200) begin
      v = toggle ? ~cyc[0] : 1'b1;
      req_valid = vmask;
      req_valid[g] = v;
      req_bit = NREQ'($urandom);
      req_bit[g] = bits[k];
      outs({tag, ".fill"}, 1'b0, NREQ'(1) << g, g, 1'b0, 0, '0);
      step();
      if (v) k++;
      cyc++;
      if (k == abort_at) begin
        reset_n = 1'b0;
        req_valid = '0;
        step();
        reset_n = 1'b1;
        ptr_m = 0;
        outs({tag, ".abort"}, 1'b0, '0, 0, 1'b1, 0, '0);
        repeat (3) begin
          step();
          outs({tag, ".quiet"}, 1'b0, '0, 0, 1'b1, 0, '0);
        end
        return;
      end
    end
    if (k < FB) chk({tag, ".fill_timeout"}, k, FB);
    req_valid = vmask;
    for (int o = ROWS - 1; o >= 0; o--) begin
      for (int c = 0; c < COLS; c++) exp_row[c] = bits[FB - 1 - (o * COLS + c)];
      if (o == stall_row) begin
        out_ready = 1'b0;
        repeat (stall_n) begin
          outs({tag, ".stall"}, 1'b1, '0, g, 1'b1, o, exp_row);
          step();
        end
        out_ready = 1'b1;
      end
      outs({tag, ".row"}, 1'b1, '0, g, 1'b1, o, exp_row);
      step();
    end
    outs({tag, ".done"}, 1'b0, '0, g, 1'b0, 0, '0);
    ptr_m = (g + 1) % NREQ;
  endtask

  initial begin
    do_reset("reset");
    frame("s1_single_one", 2'b01, FB'(1), 1'b0, -1, 0, -1);
    frame("s4_stall", 2'b01, FB'($urandom), 1'b0, 1, 4, -1);
    do_reset("reset2");
    repeat (3) frame("s3_both", 2'b11, FB'($urandom), 1'b0, -1, 0, -1);
    frame("s6_toggle", 2'b01, FB'($urandom), 1'b1, -1, 0, -1);
    frame("s5_abort", 2'b10, FB'($urandom), 1'b0, -1, 0, 7);
    frame("s5_ones", 2'b01, '1, 1'b0, -1, 0, -1);
    repeat (4) frame("rnd", NREQ'($urandom_range(1, 3)), FB'($urandom), 1'($urandom),
                     $urandom_range(0, 3), $urandom_range(1, 3), -1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule
